// File: rtl/cfg_pkg.sv
// Shared types and CRC-16-CCITT helpers for the configuration chain loader.
package cfg_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StVerify,
    StDone
  } cfg_state_e;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  // One bit-serial step, MSB-first, no reflection.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
    logic fb;
    fb = crc[15] ^ bit_in;
    return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/cfg_chain_loader_if.sv
// Bitstream stream, tile-chain pins and control/status of the chain loader.
interface cfg_chain_loader_if #(
  parameter int unsigned WORD_W = 8
);
  logic              start;
  logic [WORD_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic              cfg_din;
  logic              cfg_shift;
  logic              cfg_en;
  logic              cfg_ret;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    input  start, s_data, s_valid, cfg_ret,
    output s_ready, cfg_din, cfg_shift, cfg_en, busy, done, err
  );

  modport slave (
    output start, s_data, s_valid, cfg_ret,
    input  s_ready, cfg_din, cfg_shift, cfg_en, busy, done, err
  );
endinterface

// File: rtl/cfg_crc16_serial.sv
// Bit-serial CRC-16-CCITT accumulator with synchronous clear to the init value.
module cfg_crc16_serial
  import cfg_pkg::*;
(
  input  logic        clk,
  input  logic        nrst,
  input  logic        clear_i,
  input  logic        bit_en_i,
  input  logic        bit_in_i,
  output logic [15:0] crc_o
);

  logic [15:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clear_i) begin
      crc_d = CRC16_INIT;
    end else if (bit_en_i) begin
      crc_d = crc16_step(crc_q, bit_in_i);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      crc_q <= CRC16_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/cfg_chain_loader.sv
// Serializes a word stream MSB-first onto the tile config chain, then optionally
// rotates the chain once and compares CRC-16 of returned bits against sent bits.
module cfg_chain_loader
  import cfg_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 256,
  parameter int unsigned WORD_W    = 8,
  parameter bit          VERIFY_EN = 1'b1
) (
  input logic                clk,
  input logic                nrst,
  cfg_chain_loader_if.master bus_io
);

  localparam int unsigned NumWords = CHAIN_LEN / WORD_W;
  localparam int unsigned CntW     = $clog2(CHAIN_LEN + 1);
  localparam int unsigned WcntW    = $clog2(NumWords + 1);
  localparam int unsigned BcntW    = $clog2(WORD_W + 1);

  if ((CHAIN_LEN == 0) || ((CHAIN_LEN % WORD_W) != 0)) begin : g_len_check
    $error("CHAIN_LEN must be a non-zero multiple of WORD_W");
  end

  cfg_state_e        state_q, state_d;
  logic [WORD_W-1:0] buf_q, buf_d;
  logic [BcntW-1:0]  bcnt_q, bcnt_d;
  logic [WcntW-1:0]  wcnt_q, wcnt_d;
  logic [CntW-1:0]   scnt_q, scnt_d;
  logic              s_ready_q, s_ready_d;
  logic              cfg_din_q, cfg_din_d;
  logic              cfg_shift_q, cfg_shift_d;
  logic              cfg_en_q, cfg_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              crc_clr, tx_en, rx_en;
  logic [15:0]       tx_crc, rx_crc;

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    bcnt_d  = bcnt_q;
    wcnt_d  = wcnt_q;
    scnt_d  = scnt_q;
    err_d   = err_q;
    crc_clr = 1'b0;
    tx_en   = 1'b0;
    rx_en   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus_io.start) begin
          state_d = StLoad;
          buf_d   = '0;
          bcnt_d  = '0;
          wcnt_d  = '0;
          scnt_d  = '0;
          err_d   = 1'b0;
          crc_clr = 1'b1;
        end
      end
      StLoad: begin
        if (bcnt_q != '0) begin
          tx_en  = 1'b1;
          scnt_d = scnt_q + 1'b1;
        end
        // A word may land in the same cycle the last buffered bit leaves.
        if (s_ready_q && bus_io.s_valid) begin
          buf_d  = bus_io.s_data;
          bcnt_d = BcntW'(WORD_W);
          wcnt_d = wcnt_q + 1'b1;
        end else if (bcnt_q != '0) begin
          buf_d  = buf_q << 1;
          bcnt_d = bcnt_q - 1'b1;
        end
        if (scnt_d == CntW'(CHAIN_LEN)) begin
          state_d = VERIFY_EN ? StVerify : StDone;
          scnt_d  = '0;
        end
      end
      StVerify: begin
        rx_en  = 1'b1;
        scnt_d = scnt_q + 1'b1;
        if (scnt_d == CntW'(CHAIN_LEN)) begin
          state_d = StDone;
          err_d   = (crc16_step(rx_crc, bus_io.cfg_ret) != tx_crc);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Outputs are registered, so they are derived from the next-state values.
    s_ready_d   = (state_d == StLoad) && (bcnt_d <= BcntW'(1)) &&
                  (wcnt_d < WcntW'(NumWords));
    cfg_shift_d = ((state_d == StLoad) && (bcnt_d != '0)) || (state_d == StVerify);
    cfg_din_d   = (state_d == StLoad) && buf_d[WORD_W-1];
    cfg_en_d    = (state_d == StLoad) || (state_d == StVerify);
    busy_d      = cfg_en_d;
    done_d      = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= StIdle;
      buf_q       <= '0;
      bcnt_q      <= '0;
      wcnt_q      <= '0;
      scnt_q      <= '0;
      s_ready_q   <= 1'b0;
      cfg_din_q   <= 1'b0;
      cfg_shift_q <= 1'b0;
      cfg_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      bcnt_q      <= bcnt_d;
      wcnt_q      <= wcnt_d;
      scnt_q      <= scnt_d;
      s_ready_q   <= s_ready_d;
      cfg_din_q   <= cfg_din_d;
      cfg_shift_q <= cfg_shift_d;
      cfg_en_q    <= cfg_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  cfg_crc16_serial u_tx_crc (
    .clk      (clk),
    .nrst     (nrst),
    .clear_i  (crc_clr),
    .bit_en_i (tx_en),
    .bit_in_i (buf_q[WORD_W-1]),
    .crc_o    (tx_crc)
  );

  cfg_crc16_serial u_rx_crc (
    .clk      (clk),
    .nrst     (nrst),
    .clear_i  (crc_clr),
    .bit_en_i (rx_en),
    .bit_in_i (bus_io.cfg_ret),
    .crc_o    (rx_crc)
  );

  assign bus_io.s_ready   = s_ready_q;
  // Rotation loops the chain tail straight back to its head in the same cycle.
  assign bus_io.cfg_din   = (state_q == StVerify) ? bus_io.cfg_ret : cfg_din_q;
  assign bus_io.cfg_shift = cfg_shift_q;
  assign bus_io.cfg_en    = cfg_en_q;
  assign bus_io.busy      = busy_q;
  assign bus_io.done      = done_q;
  assign bus_io.err       = err_q;

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Two loaders (with and without readback) share one stimulus source; each drives
// its own 16-bit chain model. A cycle model and done-time scoreboards check them.
module tb_cfg_chain_loader;
  localparam int unsigned CL = 16;
  localparam int unsigned W  = 8;
  localparam int unsigned NW = CL / W;
  localparam logic [CL-1:0] FlipMask = CL'(1) << 7;

  typedef struct {
    logic [CL-1:0] chain;
    logic          err;
    int unsigned   base;
    int unsigned   shifts;
  } exp_t;
  typedef enum {MIdle, MLoad, MVer, MDone} mph_e;

  logic          clk = 1'b0;
  logic          nrst;
  logic          start;
  logic [W-1:0]  s_data;
  logic          s_valid;
  logic [CL-1:0] chain_v = '0, chain_n = '0;
  int unsigned   shcnt_v = 0, shcnt_n = 0;
  int unsigned   inj_at;
  bit            inj_en;
  logic [CL-1:0] stream;
  logic          exp_err_cur;
  logic          last_err;
  int            vec = 0;
  int            bad = 0;
  exp_t          q_v[$], q_n[$];

  mph_e mph;
  int   acc, sent, wacc, vc;
  bit   n_due;

  always #5 clk = ~clk;

  cfg_chain_loader_if #(.WORD_W(W)) bv ();
  cfg_chain_loader_if #(.WORD_W(W)) bn ();

  assign bv.start = start;
  assign bv.s_data = s_data;
  assign bv.s_valid = s_valid;
  assign bv.cfg_ret = chain_v[CL-1];
  assign bn.start = start;
  assign bn.s_data = s_data;
  assign bn.s_valid = s_valid;
  assign bn.cfg_ret = chain_n[CL-1];

  cfg_chain_loader #(.CHAIN_LEN(CL), .WORD_W(W), .VERIFY_EN(1'b1)) u_dut_v (
    .clk    (clk),
    .nrst   (nrst),
    .bus_io (bv.master)
  );

  cfg_chain_loader #(.CHAIN_LEN(CL), .WORD_W(W), .VERIFY_EN(1'b0)) u_dut_n (
    .clk    (clk),
    .nrst   (nrst),
    .bus_io (bn.master)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_crc(input logic [CL-1:0] v);
    logic [15:0] c = 16'hFFFF;
    for (int i = CL - 1; i >= 0; i--) c = (c << 1) ^ ((c[15] ^ v[i]) ? 16'h1021 : 16'h0000);
    return c;
  endfunction

  // Tile chains: shift toward the tail; bit 7 can be corrupted as the load completes.
  always @(posedge clk) begin
    if (bv.cfg_shift) begin
      chain_v <= (inj_en && shcnt_v == inj_at) ? ({chain_v[CL-2:0], bv.cfg_din} ^ FlipMask)
                                               : {chain_v[CL-2:0], bv.cfg_din};
      shcnt_v <= shcnt_v + 1;
    end
    if (bn.cfg_shift) begin
      chain_n <= {chain_n[CL-2:0], bn.cfg_din};
      shcnt_n <= shcnt_n + 1;
    end
  end

  // Cycle model: a bit can shift only once it has been handed over by a handshake.
  always @(negedge clk) begin
    if (!nrst) begin
      chk("rst_v", {bv.s_ready, bv.cfg_din, bv.cfg_shift, bv.cfg_en, bv.busy, bv.done, bv.err}, 0);
      chk("rst_n", {bn.s_ready, bn.cfg_din, bn.cfg_shift, bn.cfg_en, bn.busy, bn.done, bn.err}, 0);
      mph      <= MIdle;
      n_due    <= 1'b0;
      last_err <= 1'b0;
    end else begin
      chk("n_done_timing", bn.done, n_due);
      n_due <= 1'b0;
      case (mph)
        MIdle: begin
          chk("idle_flags", {bv.busy, bv.cfg_en, bv.cfg_shift, bv.s_ready, bv.done}, 0);
          chk("err_sticky", bv.err, last_err);
          if (start) begin
            mph  <= MLoad;
            acc  <= 0;
            sent <= 0;
            wacc <= 0;
          end
        end
        MLoad: begin
          chk("ld_en_busy_err", {bv.cfg_en, bv.busy, bv.err}, 3'b110);
          chk("ld_ready", bv.s_ready, (wacc < NW) && (acc - sent <= 1));
          chk("ld_shift", bv.cfg_shift, acc > sent);
          if (acc > sent) chk("ld_din", bv.cfg_din, stream[CL-1-sent]);
          if (s_valid && bv.s_ready) begin
            acc  <= acc + W;
            wacc <= wacc + 1;
          end
          sent <= sent + ((acc > sent) ? 1 : 0);
          if (sent + ((acc > sent) ? 1 : 0) == CL) begin
            mph   <= MVer;
            vc    <= 0;
            n_due <= 1'b1;
          end
        end
        MVer: begin
          chk("vf_flags", {bv.cfg_shift, bv.cfg_en, bv.busy, bv.s_ready, bv.done}, 5'b11100);
          chk("vf_loopback", bv.cfg_din, bv.cfg_ret);
          vc <= vc + 1;
          if (vc + 1 == CL) mph <= MDone;
        end
        MDone: begin
          chk("done_flags", {bv.done, bv.cfg_en, bv.busy, bv.cfg_shift, bv.s_ready}, 5'b10000);
          mph      <= MIdle;
          last_err <= exp_err_cur;
        end
        default: mph <= MIdle;
      endcase
    end
  end

  // Scoreboards: expected results were queued when each load was started.
  always @(negedge clk) begin
    if (nrst && bv.done) begin
      chk("v_done_expected", q_v.size() != 0, 1'b1);
      if (q_v.size() != 0) begin
        chk("v_chain", chain_v, q_v[0].chain);
        chk("v_err", bv.err, q_v[0].err);
        chk("v_shift_count", shcnt_v - q_v[0].base, q_v[0].shifts);
        q_v.delete(0);
      end
    end
    if (nrst && bn.done) begin
      chk("n_done_expected", q_n.size() != 0, 1'b1);
      if (q_n.size() != 0) begin
        chk("n_chain", chain_n, q_n[0].chain);
        chk("n_err", bn.err, q_n[0].err);
        chk("n_shift_count", shcnt_n - q_n[0].base, q_n[0].shifts);
        chk("n_en_low", bn.cfg_en, 1'b0);
        q_n.delete(0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [W-1:0] w, input int budget, output bit ok);
    s_data  = w;
    s_valid = 1'b1;
    ok      = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (bv.s_ready) ok = 1'b1;
      tick();
    end
    s_valid = 1'b0;
  endtask

  task automatic begin_op(input logic [W-1:0] w0, input logic [W-1:0] w1, input bit inj);
    exp_t e;
    stream      = {w0, w1};
    exp_err_cur = (ref_crc(stream) != ref_crc(inj ? (stream ^ FlipMask) : stream));
    e.chain = inj ? (stream ^ FlipMask) : stream;
    e.err = exp_err_cur;
    e.base = shcnt_v;
    e.shifts = 2 * CL;
    q_v.push_back(e);
    e.chain = stream;
    e.err = 1'b0;
    e.base = shcnt_n;
    e.shifts = CL;
    q_n.push_back(e);
    inj_en = inj;
    inj_at = shcnt_v + CL - 1;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 120 && !seen; i++) begin
      @(negedge clk);
      if (bv.done) seen = 1'b1;
    end
    chk("done_seen", seen, 1'b1);
    tick();
  endtask

  task automatic run_op(input logic [W-1:0] w0, input logic [W-1:0] w1, input int gap,
                        input bit inj, input bit busy_start, input bit extra);
    bit ok;
    begin_op(w0, w1, inj);
    offer(w0, 40, ok);
    chk("w0_accepted", ok, 1'b1);
    if (busy_start) begin
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    repeat (gap) tick();
    offer(w1, 60, ok);
    chk("w1_accepted", ok, 1'b1);
    if (extra) begin
      offer(8'hEE, 10, ok);
      chk("w2_rejected", ok, 1'b0);
    end
    wait_done();
  endtask

  initial begin
    bit ok;
    logic [W-1:0] ra, rb;
    nrst    = 1'b0;
    start   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    inj_en  = 1'b0;
    inj_at  = 0;
    stream  = '0;
    exp_err_cur = 1'b0;
    repeat (3) tick();
    nrst = 1'b1;
    tick();

    run_op(8'hA5, 8'h3C, 0, 1'b0, 1'b0, 1'b0);
    run_op(8'hA5, 8'h3C, 12, 1'b0, 1'b0, 1'b0);
    run_op(8'hA5, 8'h3C, 0, 1'b1, 1'b0, 1'b0);
    repeat (3) tick();
    run_op(8'hFF, 8'h00, 0, 1'b0, 1'b0, 1'b0);

    // Abort after five shifted bits; the aborted load must never report done.
    begin_op(8'h5A, 8'hC3, 1'b0);
    offer(8'h5A, 40, ok);
    chk("abort_w0_accepted", ok, 1'b1);
    repeat (5) tick();
    nrst = 1'b0;
    q_v.delete();
    q_n.delete();
    repeat (2) tick();
    nrst = 1'b1;
    tick();
    run_op(8'h12, 8'h34, 0, 1'b0, 1'b0, 1'b0);

    run_op(8'h96, 8'h69, 0, 1'b0, 1'b1, 1'b1);

    for (int k = 0; k < 8; k++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      run_op(ra, rb, int'($urandom_range(0, 12)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end
    repeat (4) tick();
    chk("v_queue_drained", q_v.size(), 0);
    chk("n_queue_drained", q_n.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
